// File: rtl/dvs_ravens_pkg.sv
// rtl/dvs_ravens_pkg.sv - shared DVS/RAVENS event widths and grant FSM state type
package dvs_ravens_pkg;

  localparam int EVENT_BITS        = 48;
  localparam int TIMESTAMP_US_BITS = 32;
  localparam int DVS_ADDR_BITS     = EVENT_BITS - TIMESTAMP_US_BITS;

  typedef enum logic [1:0] {
    GS_IDLE,
    GS_GRANT,
    GS_WAIT_RD,
    GS_HOLD
  } grant_state_e;

endpackage

// File: rtl/dvs_event_ram.sv
// rtl/dvs_event_ram.sv - event storage array, synchronous write, combinational read
module dvs_event_ram
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [EVENT_BITS-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [EVENT_BITS-1:0] rdata
);

  // Contents are deliberately not reset; occupancy alone defines what is valid.
  logic [EVENT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dvs_event_fifo_server.sv
// rtl/dvs_event_fifo_server.sv - timestamping DVS event FIFO serving the RAVENS reader via req/grant/rd_en
module dvs_event_fifo_server
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int GRANT_TIMEOUT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DVS_ADDR_BITS-1:0]     in_addr,
  input  logic [TIMESTAMP_US_BITS-1:0] time_us,
  output logic                         in_ready,
  input  logic                         fifo_req,
  input  logic                         fifo_rd_en,
  output logic                         fifo_grant,
  output logic [EVENT_BITS-1:0]        fifo_event,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic [15:0]                  drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(GRANT_TIMEOUT - 1);

  grant_state_e          state, next_state;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [TW-1:0]         wait_cnt;
  logic                  push, pop, drop;
  logic [EVENT_BITS-1:0] rd_data;

  assign in_ready = (occupancy != FULL_LVL);
  assign push     = in_valid && in_ready;
  // Full is judged on registered occupancy, so a same-edge pop never rescues an event.
  assign drop     = in_valid && !in_ready;

  dvs_event_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_addr, time_us}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= GS_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    fifo_grant = 1'b0;
    pop        = 1'b0;
    case (state)
      GS_IDLE: begin
        if (fifo_req && occupancy != '0) next_state = GS_GRANT;
      end
      GS_GRANT: begin
        fifo_grant = 1'b1;
        next_state = GS_WAIT_RD;
      end
      GS_WAIT_RD: begin
        if (fifo_rd_en) begin
          pop        = 1'b1;
          next_state = GS_HOLD;
        end else if (wait_cnt == TO_LAST) begin
          next_state = GS_IDLE;
        end
      end
      GS_HOLD: next_state = GS_IDLE;
      default: next_state = GS_IDLE;
    endcase
  end

  // Counts cycles spent in WAIT_RD; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      wait_cnt <= '0;
    else if (state != GS_WAIT_RD) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      fifo_event <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        fifo_event <= rd_data;
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + (AW+1)'(1);
        2'b01:   occupancy <= occupancy - (AW+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

endmodule
